// File: rtl/perf_counter_sampler.sv
// -----------------------------------------------------------------------------
// perf_counter_sampler
// Periodically sweeps a bank of performance counters over the CSR port and
// queues tagged samples {seq, idx, data} into a small FIFO that a consumer
// drains through a valid/ready stream.
//
// Optional feature macro: PERF_SAMPLER_CLEAR_EN
//   defined     : clear-on-read, each sampled counter is written 0 the cycle
//                 after it is read (2 cycles per sampled counter)
//   not defined : read-only sweep, perf_we_o/perf_data_o tied low
// -----------------------------------------------------------------------------
module perf_counter_sampler #(
   parameter int          NumCounters = 11,
   parameter logic [11:0] BaseAddr    = 12'hB03,
   parameter int          DataWidth   = 64,
   parameter int          FifoDepth   = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   enable_i,
   input  logic                   clear_i,
   input  logic [31:0]            period_i,
   input  logic [NumCounters-1:0] mask_i,
   output logic [11:0]            perf_addr_o,
   output logic                   perf_we_o,
   output logic [DataWidth-1:0]   perf_data_o,
   input  logic [DataWidth-1:0]   perf_data_i,
   output logic                   sample_valid_o,
   input  logic                   sample_ready_i,
   output logic [3:0]             sample_idx_o,
   output logic [15:0]            sample_seq_o,
   output logic [DataWidth-1:0]   sample_data_o,
   output logic                   overflow_o
);

   localparam int         PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam logic [3:0] LastIdx = 4'(NumCounters - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SWEEP
   } state_t;

   typedef struct packed {
      logic [15:0]          seq;
      logic [3:0]           idx;
      logic [DataWidth-1:0] data;
   } sample_t;

   // Elaboration-time parameter sanity checks
   if (int'(BaseAddr) + NumCounters - 1 > 4095) begin : g_addr_range_check
      $error("perf_counter_sampler: BaseAddr+NumCounters-1 exceeds 12'hFFF");
   end
   if (NumCounters < 1 || NumCounters > 16) begin : g_count_check
      $error("perf_counter_sampler: NumCounters must be 1..16");
   end
   if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_depth_check
      $error("perf_counter_sampler: FifoDepth must be a power of 2 and >= 2");
   end

   // Sequencer state
   state_t      r_state;
   logic [31:0] r_timer;
   logic [3:0]  r_idx;
   logic [15:0] r_seq;
   logic        r_overflow;
   logic [11:0] r_perf_addr;
`ifdef PERF_SAMPLER_CLEAR_EN
   logic        r_perf_we;
   logic        r_clr_phase;   // 1 = this cycle writes 0 to the counter just read
`endif

   // FIFO state; pointers carry one extra wrap bit to tell full from empty
   sample_t         r_mem [FifoDepth];
   logic [PtrW:0]   r_wr_ptr;
   logic [PtrW:0]   r_rd_ptr;

   logic [31:0] w_period_m1;
   logic [15:0] w_mask_ext;
   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_sel;
   logic        w_push;
   logic        w_step;
   logic [11:0] w_next_addr;
   sample_t     w_head;

   // A period of 0 behaves like a period of 1
   assign w_period_m1 = (period_i == 32'd0) ? 32'd0 : period_i - 32'd1;
   assign w_mask_ext  = 16'(mask_i);
   assign w_next_addr = BaseAddr + 12'(r_idx) + 12'd1;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                    (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);
   assign w_pop   = !w_empty && sample_ready_i;

   // A pop in the same cycle frees a slot, so a full FIFO can still accept
   assign w_sel = (r_state == ST_SWEEP) && w_mask_ext[r_idx];
`ifdef PERF_SAMPLER_CLEAR_EN
   assign w_push = w_sel && !r_clr_phase && (!w_full || w_pop);
   assign w_step = (r_state == ST_SWEEP) && (r_clr_phase || !w_mask_ext[r_idx]);
`else
   assign w_push = w_sel && (!w_full || w_pop);
   assign w_step = (r_state == ST_SWEEP) && (!w_mask_ext[r_idx] || w_push);
`endif

   // Sweep sequencer: timer, index walk, sequence number, overflow, CSR address
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values of the others, matching the hardware.
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_idx       <= '0;
         r_seq       <= '0;
         r_overflow  <= 1'b0;
         r_perf_addr <= '0;
`ifdef PERF_SAMPLER_CLEAR_EN
         r_perf_we   <= 1'b0;
         r_clr_phase <= 1'b0;
`endif
      end else if (clear_i) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_idx       <= '0;
         r_seq       <= '0;
         r_overflow  <= 1'b0;
         r_perf_addr <= '0;
`ifdef PERF_SAMPLER_CLEAR_EN
         r_perf_we   <= 1'b0;
         r_clr_phase <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable_i) begin
                  r_state <= ST_WAIT;
                  r_timer <= w_period_m1;
               end
            end
            ST_WAIT: begin
               if (!enable_i) begin
                  r_state <= ST_IDLE;
               end else if (r_timer == 32'd0) begin
                  r_state     <= ST_SWEEP;
                  r_timer     <= w_period_m1;
                  r_idx       <= '0;
                  r_perf_addr <= BaseAddr;
               end else begin
                  r_timer <= r_timer - 32'd1;
               end
            end
            ST_SWEEP: begin
               // The period keeps running; a start that lands mid-sweep is
               // dropped and only flagged
               if (r_timer == 32'd0) begin
                  r_overflow <= 1'b1;
                  r_timer    <= w_period_m1;
               end else begin
                  r_timer <= r_timer - 32'd1;
               end
`ifdef PERF_SAMPLER_CLEAR_EN
               if (w_push) begin
                  r_clr_phase <= 1'b1;
                  r_perf_we   <= 1'b1;
               end
`endif
               if (w_step) begin
`ifdef PERF_SAMPLER_CLEAR_EN
                  r_clr_phase <= 1'b0;
                  r_perf_we   <= 1'b0;
`endif
                  if (r_idx == LastIdx) begin
                     r_seq       <= r_seq + 16'd1;
                     r_idx       <= '0;
                     r_perf_addr <= '0;
                     r_state     <= enable_i ? ST_WAIT : ST_IDLE;
                  end else begin
                     r_idx       <= r_idx + 4'd1;
                     r_perf_addr <= w_next_addr;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // FIFO pointers; clear drops everything including a same-cycle push
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (clear_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // FIFO storage write
   always_ff @(posedge clk_i) begin
      // NOTE: the storage array has no reset; the head outputs are gated to 0
      // while empty, so stale entries are never visible.
      if (w_push) begin
         r_mem[r_wr_ptr[PtrW-1:0]] <= '{seq: r_seq, idx: r_idx, data: perf_data_i};
      end
   end

   assign w_head = r_mem[r_rd_ptr[PtrW-1:0]];

   assign sample_valid_o = !w_empty;
   assign sample_idx_o   = w_empty ? 4'd0  : w_head.idx;
   assign sample_seq_o   = w_empty ? 16'd0 : w_head.seq;
   assign sample_data_o  = w_empty ? '0    : w_head.data;

   assign perf_addr_o = r_perf_addr;
   assign overflow_o  = r_overflow;
   assign perf_data_o = '0;   // the only value ever written is zero
`ifdef PERF_SAMPLER_CLEAR_EN
   assign perf_we_o   = r_perf_we;
`else
   assign perf_we_o   = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_sampler.sv
// -----------------------------------------------------------------------------
// tb_perf_counter_sampler
// Directed bench for perf_counter_sampler with a behavioural counter block and
// a stream monitor. Build-dependent expectations follow PERF_SAMPLER_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_perf_counter_sampler;

   localparam int          NC   = 11;
   localparam logic [11:0] BASE = 12'hB03;

   typedef struct {
      logic [3:0]  idx;
      logic [15:0] seq;
      logic [63:0] data;
   } samp_t;

   logic          clk;
   logic          rst_i;
   logic          enable_i;
   logic          clear_i;
   logic [31:0]   period_i;
   logic [NC-1:0] mask_i;
   logic [11:0]   perf_addr_o;
   logic          perf_we_o;
   logic [63:0]   perf_data_o;
   logic [63:0]   perf_data_i;
   logic          sample_valid_o;
   logic          sample_ready_i;
   logic [3:0]    sample_idx_o;
   logic [15:0]   sample_seq_o;
   logic [63:0]   sample_data_o;
   logic          overflow_o;

   logic [63:0] counters [NC];
   samp_t       got [$];
   int          we_count;
   int          n_pass;
   int          n_total;

   perf_counter_sampler #(
      .NumCounters (NC),
      .BaseAddr    (BASE),
      .DataWidth   (64),
      .FifoDepth   (8)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .enable_i       (enable_i),
      .clear_i        (clear_i),
      .period_i       (period_i),
      .mask_i         (mask_i),
      .perf_addr_o    (perf_addr_o),
      .perf_we_o      (perf_we_o),
      .perf_data_o    (perf_data_o),
      .perf_data_i    (perf_data_i),
      .sample_valid_o (sample_valid_o),
      .sample_ready_i (sample_ready_i),
      .sample_idx_o   (sample_idx_o),
      .sample_seq_o   (sample_seq_o),
      .sample_data_o  (sample_data_o),
      .overflow_o     (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter block read port: combinational data for the presented address
   always_comb begin
      int ai;
      ai = int'(perf_addr_o) - int'(BASE);
      perf_data_i = '0;
      if (ai >= 0 && ai < NC) perf_data_i = counters[ai];
   end

   // One clock: log a pop and a CSR write seen this cycle, step, settle 1 time unit
   task automatic tick();
      bit          do_wr;
      int          wi;
      logic [63:0] wd;
      do_wr = perf_we_o;
      wi    = int'(perf_addr_o) - int'(BASE);
      wd    = perf_data_o;
      if (sample_valid_o && sample_ready_i)
         got.push_back('{idx: sample_idx_o, seq: sample_seq_o, data: sample_data_o});
      @(posedge clk);
      #1;
      if (do_wr) begin
         we_count++;
         if (wi >= 0 && wi < NC) counters[wi] = wd;
      end
   endtask

   task automatic preset_counters();
      for (int i = 0; i < NC; i++) counters[i] = 64'(100 + i);
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   // Start one sweep from IDLE, drop enable once it begins, count its cycles
   task automatic run_one_sweep(output int len, output bit ok);
      len      = 0;
      ok       = 1'b0;
      enable_i = 1'b1;
      for (int n = 0; n < 400; n++) begin
         tick();
         if (perf_addr_o != 12'h000) begin
            ok = 1'b1;
            break;
         end
      end
      enable_i = 1'b0;
      if (ok) begin
         ok = 1'b0;
         for (int n = 0; n < 400; n++) begin
            if (perf_addr_o == 12'h000) begin
               ok = 1'b1;
               break;
            end
            len++;
            tick();
         end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick();
      tick();
      n_total++; if (perf_addr_o !== 12'h000) $display("FAIL rst_addr: got %h exp 000", perf_addr_o); else n_pass++;
      n_total++; if (perf_we_o !== 1'b0) $display("FAIL rst_we: got %b exp 0", perf_we_o); else n_pass++;
      n_total++; if (perf_data_o !== 64'd0) $display("FAIL rst_wdata: got %h exp 0", perf_data_o); else n_pass++;
      n_total++; if (sample_valid_o !== 1'b0) $display("FAIL rst_valid: got %b exp 0", sample_valid_o); else n_pass++;
      n_total++; if (sample_idx_o !== 4'd0) $display("FAIL rst_idx: got %h exp 0", sample_idx_o); else n_pass++;
      n_total++; if (sample_seq_o !== 16'd0) $display("FAIL rst_seq: got %h exp 0", sample_seq_o); else n_pass++;
      n_total++; if (sample_data_o !== 64'd0) $display("FAIL rst_data: got %h exp 0", sample_data_o); else n_pass++;
      n_total++; if (overflow_o !== 1'b0) $display("FAIL rst_ovf: got %b exp 0", overflow_o); else n_pass++;
      rst_i = 1'b0;
      tick();
   endtask

   // Periodic sweeps: enable is taken at the first edge, a sweep starts P edges
   // later, and subsequent sweeps start every P edges
   task automatic test_periodic();
      int          starts [$];
      logic [11:0] prev;
      preset_counters();
      got.delete();
      period_i       = 32'd12;
      mask_i         = '1;
      sample_ready_i = 1'b1;
      enable_i       = 1'b1;
      prev           = perf_addr_o;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (perf_addr_o == BASE && prev != BASE) starts.push_back(n);
         prev = perf_addr_o;
      end
      enable_i = 1'b0;   // third sweep is in flight and must still complete
      for (int n = 0; n < 25; n++) tick();
      n_total++; if (starts.size() != 3) $display("FAIL per_starts: got %0d sweeps exp 3", starts.size()); else n_pass++;
      if (starts.size() == 3) begin
         n_total++; if (starts[0] != 13) $display("FAIL per_first: got %0d exp 13", starts[0]); else n_pass++;
         n_total++; if (starts[1] != 25) $display("FAIL per_second: got %0d exp 25", starts[1]); else n_pass++;
         n_total++; if (starts[2] != 37) $display("FAIL per_third: got %0d exp 37", starts[2]); else n_pass++;
      end
      n_total++; if (got.size() != 33) $display("FAIL per_count: got %0d exp 33", got.size()); else n_pass++;
      for (int s = 0; s < got.size() && s < 33; s++) begin
         n_total++;
         if (got[s].idx !== 4'(s % 11) || got[s].seq !== 16'(s / 11) || got[s].data !== 64'(100 + s % 11))
            $display("FAIL per_sample%0d: got idx %0d seq %0d data %0d exp idx %0d seq %0d data %0d",
                     s, got[s].idx, got[s].seq, got[s].data, s % 11, s / 11, 100 + s % 11);
         else n_pass++;
      end
      n_total++; if (overflow_o !== 1'b0) $display("FAIL per_ovf: got %b exp 0", overflow_o); else n_pass++;
      n_total++; if (perf_addr_o !== 12'h000) $display("FAIL per_idle_addr: got %h exp 000", perf_addr_o); else n_pass++;
   endtask

   // Sparse mask: only idx 0 and 2 pushed, every index still visited
   task automatic test_mask();
      int          len;
      bit          ok;
      int          exp_len;
      logic [63:0] exp_d0;
      logic [63:0] exp_d2;
      do_clear();
      preset_counters();
      got.delete();
      we_count       = 0;
      period_i       = 32'd20;
      mask_i         = 11'b000_0000_0101;
      sample_ready_i = 1'b1;
`ifdef PERF_SAMPLER_CLEAR_EN
      exp_len = 13;
`else
      exp_len = 11;
`endif
      run_one_sweep(len, ok);
      n_total++; if (!ok) $display("FAIL mask_sweep1_timeout: got timeout exp sweep"); else n_pass++;
      n_total++; if (len != exp_len) $display("FAIL mask_len: got %0d exp %0d", len, exp_len); else n_pass++;
      for (int n = 0; n < 5; n++) tick();
      run_one_sweep(len, ok);
      n_total++; if (!ok) $display("FAIL mask_sweep2_timeout: got timeout exp sweep"); else n_pass++;
      for (int n = 0; n < 5; n++) tick();
      n_total++; if (got.size() != 4) $display("FAIL mask_count: got %0d exp 4", got.size()); else n_pass++;
      if (got.size() == 4) begin
         n_total++;
         if (got[0].idx !== 4'd0 || got[0].seq !== 16'd0 || got[0].data !== 64'd100)
            $display("FAIL mask_s0: got %0d/%0d/%0d exp 0/0/100", got[0].idx, got[0].seq, got[0].data);
         else n_pass++;
         n_total++;
         if (got[1].idx !== 4'd2 || got[1].seq !== 16'd0 || got[1].data !== 64'd102)
            $display("FAIL mask_s1: got %0d/%0d/%0d exp 2/0/102", got[1].idx, got[1].seq, got[1].data);
         else n_pass++;
`ifdef PERF_SAMPLER_CLEAR_EN
         exp_d0 = 64'd0;
         exp_d2 = 64'd0;
`else
         exp_d0 = 64'd100;
         exp_d2 = 64'd102;
`endif
         n_total++;
         if (got[2].idx !== 4'd0 || got[2].seq !== 16'd1 || got[2].data !== exp_d0)
            $display("FAIL mask_s2: got %0d/%0d/%0d exp 0/1/%0d", got[2].idx, got[2].seq, got[2].data, exp_d0);
         else n_pass++;
         n_total++;
         if (got[3].idx !== 4'd2 || got[3].seq !== 16'd1 || got[3].data !== exp_d2)
            $display("FAIL mask_s3: got %0d/%0d/%0d exp 2/1/%0d", got[3].idx, got[3].seq, got[3].data, exp_d2);
         else n_pass++;
      end
`ifdef PERF_SAMPLER_CLEAR_EN
      n_total++; if (we_count != 4) $display("FAIL mask_we_count: got %0d exp 4", we_count); else n_pass++;
      n_total++; if (counters[1] !== 64'd101) $display("FAIL mask_skip_kept: got %0d exp 101", counters[1]); else n_pass++;
      n_total++; if (counters[0] !== 64'd0) $display("FAIL mask_cleared: got %0d exp 0", counters[0]); else n_pass++;
`else
      n_total++; if (we_count != 0) $display("FAIL mask_we_count: got %0d exp 0", we_count); else n_pass++;
`endif
   endtask

   // Back-pressure: 8 entries fill, sweep stalls at idx 8, nothing is lost
   task automatic test_back_to_back();
      bit ok;
      do_clear();
      preset_counters();
      got.delete();
      period_i       = 32'd100;
      mask_i         = '1;
      sample_ready_i = 1'b0;
      enable_i       = 1'b1;
      ok             = 1'b0;
      for (int n = 0; n < 300; n++) begin
         tick();
         if (perf_addr_o != 12'h000) begin
            ok = 1'b1;
            break;
         end
      end
      enable_i = 1'b0;
      n_total++; if (!ok) $display("FAIL bp_start_timeout: got timeout exp sweep"); else n_pass++;
      for (int n = 0; n < 20; n++) tick();
      n_total++; if (perf_addr_o !== BASE + 12'd8) $display("FAIL bp_stall_addr: got %h exp %h", perf_addr_o, BASE + 12'd8); else n_pass++;
      n_total++; if (sample_valid_o !== 1'b1) $display("FAIL bp_valid: got %b exp 1", sample_valid_o); else n_pass++;
      n_total++; if (sample_idx_o !== 4'd0 || sample_data_o !== 64'd100)
         $display("FAIL bp_head: got idx %0d data %0d exp idx 0 data 100", sample_idx_o, sample_data_o); else n_pass++;
      // One ready cycle while full: pop and push on the same edge
      sample_ready_i = 1'b1;
      tick();
      sample_ready_i = 1'b0;
      for (int n = 0; n < 6; n++) tick();
      n_total++; if (perf_addr_o !== BASE + 12'd9) $display("FAIL bp_full_pop_addr: got %h exp %h", perf_addr_o, BASE + 12'd9); else n_pass++;
      n_total++; if (sample_idx_o !== 4'd1) $display("FAIL bp_head_after_pop: got %0d exp 1", sample_idx_o); else n_pass++;
      sample_ready_i = 1'b1;
      for (int n = 0; n < 30; n++) tick();
      n_total++; if (got.size() != 11) $display("FAIL bp_count: got %0d exp 11", got.size()); else n_pass++;
      for (int s = 0; s < got.size() && s < 11; s++) begin
         n_total++;
         if (got[s].idx !== 4'(s) || got[s].seq !== 16'd0 || got[s].data !== 64'(100 + s))
            $display("FAIL bp_sample%0d: got idx %0d seq %0d data %0d exp idx %0d seq 0 data %0d",
                     s, got[s].idx, got[s].seq, got[s].data, s, 100 + s);
         else n_pass++;
      end
      n_total++; if (perf_addr_o !== 12'h000) $display("FAIL bp_done_addr: got %h exp 000", perf_addr_o); else n_pass++;
   endtask

   // Missed start sets sticky overflow; clear flushes everything next cycle
   task automatic test_overflow_clear();
      int len;
      bit ok;
      do_clear();
      preset_counters();
      got.delete();
      period_i       = 32'd5;
      mask_i         = '1;
      sample_ready_i = 1'b0;
      enable_i       = 1'b1;
      for (int n = 0; n < 25; n++) tick();
      n_total++; if (overflow_o !== 1'b1) $display("FAIL ovf_set: got %b exp 1", overflow_o); else n_pass++;
      for (int n = 0; n < 10; n++) tick();
      n_total++; if (overflow_o !== 1'b1) $display("FAIL ovf_sticky: got %b exp 1", overflow_o); else n_pass++;
      n_total++; if (sample_valid_o !== 1'b1) $display("FAIL ovf_valid: got %b exp 1", sample_valid_o); else n_pass++;
      clear_i = 1'b1;
      #1;
      n_total++; if (overflow_o !== 1'b1) $display("FAIL clr_sync: got %b exp 1", overflow_o); else n_pass++;
      tick();
      clear_i  = 1'b0;
      enable_i = 1'b0;
      n_total++; if (sample_valid_o !== 1'b0) $display("FAIL clr_valid: got %b exp 0", sample_valid_o); else n_pass++;
      n_total++; if (overflow_o !== 1'b0) $display("FAIL clr_ovf: got %b exp 0", overflow_o); else n_pass++;
      n_total++; if (perf_addr_o !== 12'h000) $display("FAIL clr_addr: got %h exp 000", perf_addr_o); else n_pass++;
      n_total++; if (sample_seq_o !== 16'd0) $display("FAIL clr_seq_out: got %0d exp 0", sample_seq_o); else n_pass++;
      for (int n = 0; n < 8; n++) tick();
      n_total++; if (overflow_o !== 1'b0 || perf_addr_o !== 12'h000)
         $display("FAIL clr_quiet: got ovf %b addr %h exp ovf 0 addr 000", overflow_o, perf_addr_o); else n_pass++;
      // The sequence number restarts from 0 after a clear
      got.delete();
      preset_counters();
      period_i       = 32'd100;
      sample_ready_i = 1'b1;
      run_one_sweep(len, ok);
      for (int n = 0; n < 5; n++) tick();
      n_total++; if (!ok) $display("FAIL clr_sweep_timeout: got timeout exp sweep"); else n_pass++;
      n_total++; if (got.size() != 11) $display("FAIL clr_count: got %0d exp 11", got.size()); else n_pass++;
      if (got.size() > 0) begin
         n_total++; if (got[0].seq !== 16'd0) $display("FAIL clr_seq_restart: got %0d exp 0", got[0].seq); else n_pass++;
      end
   endtask

   // Async reset mid-sweep: outputs drop without waiting for an edge
   task automatic test_reset_mid_sweep();
      bit ok;
      do_clear();
      preset_counters();
      period_i       = 32'd100;
      mask_i         = '1;
      sample_ready_i = 1'b0;
      enable_i       = 1'b1;
      ok             = 1'b0;
      for (int n = 0; n < 300; n++) begin
         tick();
         if (perf_addr_o == BASE + 12'd3) begin
            ok = 1'b1;
            break;
         end
      end
      n_total++; if (!ok) $display("FAIL rsw_timeout: got timeout exp addr %h", BASE + 12'd3); else n_pass++;
      n_total++; if (sample_valid_o !== 1'b1) $display("FAIL rsw_pre_valid: got %b exp 1", sample_valid_o); else n_pass++;
      enable_i = 1'b0;
      #1;
      rst_i = 1'b1;
      #1;
      n_total++; if (perf_addr_o !== 12'h000) $display("FAIL rsw_addr: got %h exp 000", perf_addr_o); else n_pass++;
      n_total++; if (sample_valid_o !== 1'b0) $display("FAIL rsw_valid: got %b exp 0", sample_valid_o); else n_pass++;
      n_total++; if (sample_idx_o !== 4'd0 || sample_seq_o !== 16'd0 || sample_data_o !== 64'd0)
         $display("FAIL rsw_head: got %0d/%0d/%0d exp 0/0/0", sample_idx_o, sample_seq_o, sample_data_o); else n_pass++;
      n_total++; if (perf_we_o !== 1'b0 || overflow_o !== 1'b0)
         $display("FAIL rsw_we_ovf: got we %b ovf %b exp 0 0", perf_we_o, overflow_o); else n_pass++;
      tick();
      rst_i = 1'b0;
      for (int n = 0; n < 20; n++) tick();
      n_total++; if (perf_addr_o !== 12'h000 || sample_valid_o !== 1'b0)
         $display("FAIL rsw_no_resume: got addr %h valid %b exp 000 0", perf_addr_o, sample_valid_o); else n_pass++;
   endtask

   initial begin
      n_pass         = 0;
      n_total        = 0;
      we_count       = 0;
      rst_i          = 1'b1;
      enable_i       = 1'b0;
      clear_i        = 1'b0;
      period_i       = 32'd10;
      mask_i         = '1;
      sample_ready_i = 1'b1;
      preset_counters();
      test_reset();
`ifndef PERF_SAMPLER_CLEAR_EN
      test_periodic();
`endif
      test_mask();
      test_back_to_back();
      test_overflow_clear();
      test_reset_mid_sweep();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
